// File: rtl/m5_cas_player_if.sv
// HPS ioctl download port as seen by the CAS playback stage.
// Handshake: a byte is transferred on every cycle with ioctl_wr=1 (valid, no ready);
// ioctl_wait_o is advisory backpressure, and a write arriving while the buffer is full is lost.
interface m5_cas_player_if;
  logic       ioctl_download;
  logic [7:0] ioctl_index;
  logic       ioctl_wr;
  logic [7:0] ioctl_dout;
  logic       ioctl_wait_o;

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_dout,
    input  ioctl_wait_o
  );

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_dout,
    output ioctl_wait_o
  );
endinterface

// File: rtl/m5_cas_player.sv
// Sord M5 tape playback: buffers the "Load Tape" download in a FIFO and plays it
// as an FSK square wave (leader, then start/8 data LSB-first/2 stop per byte).
module m5_cas_player #(
  parameter int         FIFO_AW     = 4,
  parameter int         HALF0_TICKS = 4474,
  parameter int         HALF1_TICKS = 2237,
  parameter int         LEADER_BITS = 3600,
  parameter logic [7:0] CAS_INDEX   = 8'd2
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              clk_en_i,
  m5_cas_player_if.slave    ioctl,
  input  logic              cas_speed_i,
  input  logic              motor_i,
  output logic              cas_o,
  output logic              playing_o,
  output logic              overflow_o,
  output logic [2:0]        dbg_state_o
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CNT_W = FIFO_AW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LEADER, S_FETCH, S_START, S_DATA, S_STOP, S_FILL
  } state_t;

  state_t               state;
  logic [7:0]           mem [DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr, rd_ptr, wr_addr;
  logic [CNT_W-1:0]     count, count_nxt;
  logic                 wait_q, sel, sel_q, sel_rise;
  logic                 push, push_ok, wr_en, pop, full, empty;
  logic [7:0]           rd_data, shreg;
  logic [12:0]          tick;
  logic [1:0]           half;
  logic                 cur_bit, last_half, in_bit, adv, bit_done;
  logic                 bit_start, bit_val;
  logic [2:0]           bit_cnt;
  logic [15:0]          lead_cnt;

  // Half-period length; a speed-up that truncates to zero still lasts one tick.
  function automatic logic [12:0] half_len(input logic b, input logic spd);
    logic [12:0] n;
    n = b ? 13'(HALF1_TICKS) : 13'(HALF0_TICKS);
    if (spd) n = n >> 2;
    if (n == 13'd0) n = 13'd1;
    return n;
  endfunction

  assign sel      = ioctl.ioctl_download & (ioctl.ioctl_index == CAS_INDEX);
  assign sel_rise = sel & ~sel_q;
  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign push     = ioctl.ioctl_wr & sel;
  assign push_ok  = push & ~full;
  assign wr_en    = push & (sel_rise | ~full);
  assign wr_addr  = sel_rise ? '0 : wr_ptr;
  assign pop      = motor_i & (state == S_FETCH) & ~empty & ~sel_rise;
  assign rd_data  = mem[rd_ptr];

  assign ioctl.ioctl_wait_o = wait_q;
  assign dbg_state_o        = state;

  always_comb begin
    if (sel_rise) count_nxt = CNT_W'(push);
    else          count_nxt = count + CNT_W'(push_ok) - CNT_W'(pop);
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_addr] <= ioctl.ioctl_dout;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      wait_q     <= 1'b0;
      overflow_o <= 1'b0;
      sel_q      <= 1'b0;
    end else begin
      sel_q  <= sel;
      count  <= count_nxt;
      wait_q <= (count_nxt >= CNT_W'(DEPTH - 2));
      if (sel_rise) begin
        rd_ptr     <= '0;
        wr_ptr     <= FIFO_AW'(push);
        overflow_o <= 1'b0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop)     rd_ptr <= rd_ptr + 1'b1;
        if (push & full) overflow_o <= 1'b1;
      end
    end
  end

  assign adv       = motor_i & clk_en_i;
  assign in_bit    = (state == S_LEADER) | (state == S_START) | (state == S_DATA) |
                     (state == S_STOP) | (state == S_FILL);
  assign last_half = cur_bit ? (half == 2'd3) : (half == 2'd1);
  assign bit_done  = adv & in_bit & (tick <= 13'd1) & last_half;

  // Which bit (if any) begins this cycle; shared by every path into a new bit cell.
  always_comb begin
    bit_start = 1'b0;
    bit_val   = 1'b1;
    if (sel_rise) begin
      bit_start = 1'b1;
    end else if (motor_i && state == S_FETCH) begin
      if (!empty) begin
        bit_start = 1'b1;
        bit_val   = 1'b0;
      end else if (sel) begin
        bit_start = 1'b1;
      end
    end else if (bit_done) begin
      case (state)
        S_LEADER: bit_start = (lead_cnt != 16'd0);
        S_START: begin
          bit_start = 1'b1;
          bit_val   = shreg[0];
        end
        S_DATA: begin
          bit_start = 1'b1;
          bit_val   = (bit_cnt == 3'd7) ? 1'b1 : shreg[1];
        end
        S_STOP:  bit_start = (bit_cnt == 3'd0);
        default: bit_start = 1'b0;
      endcase
    end
  end

  // Bit-cell engine: a '0' is one high/low cycle, a '1' is two, each half counted down to 1.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tick    <= '0;
      half    <= '0;
      cur_bit <= 1'b0;
      cas_o   <= 1'b0;
    end else if (bit_start) begin
      cur_bit <= bit_val;
      half    <= 2'd0;
      cas_o   <= 1'b1;
      tick    <= half_len(bit_val, cas_speed_i);
    end else if (adv && in_bit) begin
      if (tick > 13'd1) begin
        tick <= tick - 13'd1;
      end else if (!last_half) begin
        half  <= half + 2'd1;
        cas_o <= ~cas_o;
        tick  <= half_len(cur_bit, cas_speed_i);
      end
    end else if (state == S_IDLE) begin
      cas_o <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state     <= S_IDLE;
      playing_o <= 1'b0;
      lead_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
    end else if (sel_rise) begin
      state     <= S_LEADER;
      playing_o <= 1'b1;
      lead_cnt  <= 16'(LEADER_BITS - 1);
    end else if (motor_i) begin
      case (state)
        S_IDLE: ;
        S_FETCH: begin
          if (!empty) begin
            shreg <= rd_data;
            state <= S_START;
          end else if (sel) begin
            state <= S_FILL;
          end else begin
            state     <= S_IDLE;
            playing_o <= 1'b0;
          end
        end
        S_LEADER: if (bit_done) begin
          if (lead_cnt == 16'd0) state <= S_FETCH;
          else                   lead_cnt <= lead_cnt - 16'd1;
        end
        S_START: if (bit_done) begin
          state   <= S_DATA;
          bit_cnt <= 3'd0;
        end
        S_DATA: if (bit_done) begin
          if (bit_cnt == 3'd7) begin
            state   <= S_STOP;
            bit_cnt <= 3'd0;
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
            shreg   <= shreg >> 1;
          end
        end
        S_STOP: if (bit_done) begin
          if (bit_cnt == 3'd0) bit_cnt <= 3'd1;
          else                 state   <= S_FETCH;
        end
        S_FILL: if (bit_done) state <= S_FETCH;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_m5_cas_player.sv
// Bench for m5_cas_player: plays downloads and compares cas_o/playing_o cycle by cycle
// against a waveform built from the bit-cell and framing rules.
module tb_m5_cas_player;
  localparam int H0 = 8;
  localparam int H1 = 4;
  localparam int LB = 2;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       clk_en_i;
  logic       cas_speed_i;
  logic       motor_i;
  logic       cas_o, playing_o, overflow_o;
  logic [2:0] dbg_state;

  int vectors = 0;
  int miscompares = 0;

  logic [0:0] exp_q[$];
  logic [7:0] sb[8];

  m5_cas_player_if bus();

  m5_cas_player #(
    .FIFO_AW(2), .HALF0_TICKS(H0), .HALF1_TICKS(H1), .LEADER_BITS(LB), .CAS_INDEX(8'd2)
  ) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .clk_en_i    (clk_en_i),
    .ioctl       (bus),
    .cas_speed_i (cas_speed_i),
    .motor_i     (motor_i),
    .cas_o       (cas_o),
    .playing_o   (playing_o),
    .overflow_o  (overflow_o),
    .dbg_state_o (dbg_state)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int half_ticks(input bit b, input bit spd);
    int n;
    n = b ? H1 : H0;
    if (spd) n = n / 4;
    if (n < 1) n = 1;
    return n;
  endfunction

  function automatic int bit_cycles(input bit b, input bit spd);
    return b ? 4 * half_ticks(1'b1, spd) : 2 * half_ticks(1'b0, spd);
  endfunction

  // Leader plus the one-cycle fetch gap: index of the first frame sample.
  function automatic int lead_len(input bit spd);
    return LB * bit_cycles(1'b1, spd) + 1;
  endfunction

  task automatic add_bit(input bit b, input bit spd);
    int h;
    h = half_ticks(b, spd);
    repeat (b ? 2 : 1) begin
      repeat (h) exp_q.push_back(1'b1);
      repeat (h) exp_q.push_back(1'b0);
    end
  endtask

  task automatic add_frame(input logic [7:0] d, input bit spd);
    add_bit(1'b0, spd);
    for (int i = 0; i < 8; i++) add_bit(d[i], spd);
    add_bit(1'b1, spd);
    add_bit(1'b1, spd);
    exp_q.push_back(1'b0);
  endtask

  // One download: n_early bytes written right after the sel rise, optional underrun
  // fillers followed by one late byte, optional 50-cycle motor stop, optional early abort.
  task automatic session(input int n_early, input bit spd, input int n_fill,
                         input int motor_at, input int abort_at);
    int late_w, fill_start, cnt, wr_n;
    logic [0:0] lvl;
    bit done;
    exp_q.delete();
    late_w = -1;
    fill_start = 0;
    for (int i = 0; i < LB; i++) add_bit(1'b1, spd);
    exp_q.push_back(1'b0);
    for (int i = 0; i < n_early && i < 4; i++) add_frame(sb[i], spd);
    for (int k = 0; k < n_fill; k++) begin
      fill_start = exp_q.size();
      add_bit(1'b1, spd);
      exp_q.push_back(1'b0);
    end
    if (n_fill > 0) begin
      late_w = fill_start + 1;
      add_frame(sb[n_early], spd);
    end
    if (motor_at > 0) begin
      lvl = exp_q[motor_at - 1];
      for (int k = 0; k < 50; k++) exp_q.insert(motor_at, lvl);
      if (late_w >= motor_at) late_w += 50;
    end

    @(negedge clk_i);
    bus.ioctl_download = 1'b1;
    bus.ioctl_index    = 8'd2;
    bus.ioctl_wr       = 1'b0;
    cas_speed_i        = spd;
    motor_i            = 1'b1;
    done = 0;
    for (int j = 0; j < 20000 && !done; j++) begin
      @(negedge clk_i);
      if (exp_q.size() == 0) begin
        chk("idle_cas", 16'(cas_o), 16'(0));
        chk("idle_playing", 16'(playing_o), 16'(0));
        chk("end_overflow", 16'(overflow_o), 16'(n_early > 4));
        chk("end_wait", 16'(bus.ioctl_wait_o), 16'(0));
        done = 1;
      end else begin
        lvl = exp_q.pop_front();
        chk("cas", 16'(cas_o), 16'(lvl));
        chk("playing", 16'(playing_o), 16'(1));
        if (j <= n_early + 1) begin
          wr_n = (j < n_early) ? j : n_early;
          cnt  = (wr_n < 4) ? wr_n : 4;
          chk("wait", 16'(bus.ioctl_wait_o), 16'(cnt >= 2));
          chk("overflow", 16'(overflow_o), 16'(wr_n > 4));
        end
        bus.ioctl_wr = 1'b0;
        if (j < n_early) begin
          bus.ioctl_wr   = 1'b1;
          bus.ioctl_dout = sb[j];
        end else if (j == late_w - 1) begin
          bus.ioctl_wr   = 1'b1;
          bus.ioctl_dout = sb[n_early];
        end
        if ((n_fill == 0 && j == n_early) || j == late_w) bus.ioctl_download = 1'b0;
        if (motor_at > 0) motor_i = !((j + 1) >= motor_at && (j + 1) < motor_at + 50);
        if (j == abort_at) done = 1;
      end
    end
    chk("session_end", 16'(done), 16'(1));
    motor_i = 1'b1;
  endtask

  initial begin
    int pos, n_e, n_f, m_at, minb;
    bit spd;
    reset_i = 1'b1;
    clk_en_i = 1'b1;
    cas_speed_i = 1'b0;
    motor_i = 1'b1;
    bus.ioctl_download = 1'b0;
    bus.ioctl_index = 8'd0;
    bus.ioctl_wr = 1'b0;
    bus.ioctl_dout = 8'd0;
    repeat (3) @(negedge clk_i);
    chk("rst_cas", 16'(cas_o), 16'(0));
    chk("rst_playing", 16'(playing_o), 16'(0));
    chk("rst_wait", 16'(bus.ioctl_wait_o), 16'(0));
    chk("rst_overflow", 16'(overflow_o), 16'(0));
    reset_i = 1'b0;
    repeat (2) @(negedge clk_i);

    // Single byte A5 at normal and 4x speed.
    sb[0] = 8'hA5;
    session(1, 1'b0, 0, 0, -1);
    session(1, 1'b1, 0, 0, -1);

    // Burst of six writes into a four-deep FIFO: last two dropped.
    for (int i = 0; i < 6; i++) sb[i] = 8'(($urandom_range(0, 255)));
    session(6, 1'b0, 0, 0, -1);

    // Underrun after 8'h00: three filler '1' bits, then the late byte.
    sb[0] = 8'h00;
    sb[1] = 8'h3C;
    session(1, 1'b0, 3, 0, -1);

    // Motor stop for 50 cycles inside the first data bit.
    sb[0] = 8'hA5;
    session(1, 1'b0, 0, lead_len(1'b0) + bit_cycles(1'b0, 1'b0) + 5, -1);

    // Reset in the middle of a data bit with bytes still queued.
    for (int i = 0; i < 4; i++) sb[i] = 8'hA5;
    session(4, 1'b0, 0, 0, lead_len(1'b0) + bit_cycles(1'b0, 1'b0) + 6);
    reset_i = 1'b1;
    bus.ioctl_download = 1'b0;
    bus.ioctl_wr = 1'b0;
    @(negedge clk_i);
    chk("mid_rst_cas", 16'(cas_o), 16'(0));
    chk("mid_rst_playing", 16'(playing_o), 16'(0));
    chk("mid_rst_wait", 16'(bus.ioctl_wait_o), 16'(0));
    reset_i = 1'b0;
    repeat (20) begin
      @(negedge clk_i);
      chk("post_rst_cas", 16'(cas_o), 16'(0));
      chk("post_rst_playing", 16'(playing_o), 16'(0));
    end

    // New sel rise during the first stop bit restarts the leader and flushes the FIFO.
    sb[0] = 8'hA5;
    sb[1] = 8'h11;
    sb[2] = 8'h22;
    pos = lead_len(1'b0) + bit_cycles(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) pos += bit_cycles(sb[0][i], 1'b0);
    session(3, 1'b0, 0, 0, pos + 3);
    bus.ioctl_download = 1'b0;
    sb[0] = 8'h5A;
    session(1, 1'b0, 0, 0, -1);

    // Randomized downloads.
    for (int it = 0; it < 14; it++) begin
      spd = 1'($urandom_range(0, 1));
      n_f = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      n_e = (n_f > 0) ? 1 : $urandom_range(1, 6);
      for (int i = 0; i < 8; i++) sb[i] = 8'($urandom_range(0, 255));
      minb = (bit_cycles(1'b0, spd) < bit_cycles(1'b1, spd)) ? bit_cycles(1'b0, spd)
                                                              : bit_cycles(1'b1, spd);
      m_at = ($urandom_range(0, 1) == 1) ? lead_len(spd) + $urandom_range(1, 10 * minb) : 0;
      session(n_e, spd, n_f, m_at, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
